// File: rtl/ibuf_write_packer.sv
// Write-port feeder for the shared input-buffer RAM: turns a 256-bit beat stream into
// tagged buffer writes, widening 8-bit beats into two 16-bit-lane words.
module ibuf_write_packer #(
  parameter int MEM_DATA_WIDTH = 256,
  parameter int TAG_W          = 1,
  parameter int WR_ADDR_W      = 14,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [TAG_W-1:0]              cfg_tag,
  input  logic [WR_ADDR_W-TAG_W-1:0]    cfg_base_addr,
  input  logic [CNT_W-1:0]              cfg_num_beats,
  input  logic                          cfg_mode_8bit,
  input  logic                          cfg_sign_ext,
  input  logic [MEM_DATA_WIDTH-1:0]     s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          mem_write_req,
  output logic [WR_ADDR_W-1:0]          mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0]     mem_write_data,
  output logic                          busy,
  output logic                          done
);

  localparam int OFF_W  = WR_ADDR_W - TAG_W;
  localparam int HALF_W = MEM_DATA_WIDTH / 2;
  localparam int LANES  = MEM_DATA_WIDTH / 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              state_r;
  logic [TAG_W-1:0]    tag_r;
  logic [OFF_W-1:0]    ptr_r;
  logic [CNT_W-1:0]    num_beats_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                mode_8bit_r;
  logic                sign_ext_r;
  logic [HALF_W-1:0]   hold_r;
  logic [CNT_W-1:0]    cnt_next_s;

  // Widen one half-beat of bytes into 16-bit lanes (byte i -> lane i).
  function automatic logic [MEM_DATA_WIDTH-1:0] widen(input logic [HALF_W-1:0] bytes,
                                                      input logic sign_ext);
    logic [7:0] b;
    widen = '0;
    for (int i = 0; i < LANES; i++) begin
      b = bytes[i*8 +: 8];
      widen[i*16 +: 16] = {{8{sign_ext & b[7]}}, b};
    end
  endfunction

  assign cnt_next_s = cnt_r + CNT_W'(1);
  assign s_ready    = (state_r == ST_RUN);

  // Transfer FSM with registered write, busy and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      tag_r          <= '0;
      ptr_r          <= '0;
      num_beats_r    <= '0;
      cnt_r          <= '0;
      mode_8bit_r    <= 1'b0;
      sign_ext_r     <= 1'b0;
      hold_r         <= '0;
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_write_req <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            tag_r       <= cfg_tag;
            ptr_r       <= cfg_base_addr;
            num_beats_r <= cfg_num_beats;
            mode_8bit_r <= cfg_mode_8bit;
            sign_ext_r  <= cfg_sign_ext;
            cnt_r       <= '0;
            if (cfg_num_beats == '0) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (s_valid) begin
            mem_write_req  <= 1'b1;
            mem_write_addr <= {tag_r, ptr_r};
            ptr_r          <= ptr_r + OFF_W'(1);
            cnt_r          <= cnt_next_s;
            if (mode_8bit_r) begin
              mem_write_data <= widen(s_data[HALF_W-1:0], sign_ext_r);
              hold_r         <= s_data[MEM_DATA_WIDTH-1:HALF_W];
              state_r        <= ST_SPLIT;
            end else begin
              mem_write_data <= s_data;
              if (cnt_next_s == num_beats_r) begin
                state_r <= ST_FIN;
              end
            end
          end
        end
        ST_SPLIT: begin
          mem_write_req  <= 1'b1;
          mem_write_addr <= {tag_r, ptr_r};
          mem_write_data <= widen(hold_r, sign_ext_r);
          ptr_r          <= ptr_r + OFF_W'(1);
          state_r        <= (cnt_r == num_beats_r) ? ST_FIN : ST_RUN;
        end
        ST_FIN: begin
          // First FIN cycle carries the final write; the done pulse follows it.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_write_packer.sv
// Directed self-checking bench for ibuf_write_packer: per-scenario tasks with
// hand-computed addresses, widened words and done/busy timing.
module tb_ibuf_write_packer;

  logic         clk;
  logic         reset;
  logic         cfg_start;
  logic [0:0]   cfg_tag;
  logic [12:0]  cfg_base_addr;
  logic [15:0]  cfg_num_beats;
  logic         cfg_mode_8bit;
  logic         cfg_sign_ext;
  logic [255:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         mem_write_req;
  logic [13:0]  mem_write_addr;
  logic [255:0] mem_write_data;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           wr_cyc_q[$];
  logic [13:0]  wr_addr_q[$];
  logic [255:0] wr_data_q[$];
  logic         wr_ready_q[$];
  int           done_cyc_q[$];
  logic         done_busy_q[$];
  bit           ready_seen;
  logic [255:0] beat_mem [0:7];

  ibuf_write_packer dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_tag(cfg_tag),
    .cfg_base_addr(cfg_base_addr), .cfg_num_beats(cfg_num_beats),
    .cfg_mode_8bit(cfg_mode_8bit), .cfg_sign_ext(cfg_sign_ext),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record writes, done pulses and ready activity mid-cycle.
  always @(negedge clk) begin
    if (mem_write_req === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(mem_write_addr);
      wr_data_q.push_back(mem_write_data);
      wr_ready_q.push_back(s_ready);
    end
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_busy_q.push_back(busy);
    end
    if (s_ready === 1'b1) ready_seen = 1'b1;
  end

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_ready_q.delete();
    done_cyc_q.delete(); done_busy_q.delete(); ready_seen = 1'b0;
  endtask

  task automatic do_start(input logic tag, input logic [12:0] base, input logic [15:0] num,
                          input logic mode8, input logic sign, output int sc);
    @(negedge clk);
    cfg_tag = tag; cfg_base_addr = base; cfg_num_beats = num;
    cfg_mode_8bit = mode8; cfg_sign_ext = sign; cfg_start = 1'b1;
    sc = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [15:0] vpat, input logic pulse_start);
    int k = 0;
    int t = 0;
    logic hs;
    while (k < n && t < 200) begin
      s_valid = vpat[t % 16];
      s_data  = beat_mem[k];
      if (pulse_start && (t % 3 == 1)) begin
        cfg_start = 1'b1; cfg_base_addr = 13'h0777; cfg_num_beats = 16'd1;
      end else begin
        cfg_start = 1'b0;
      end
      hs = s_valid & s_ready;
      @(negedge clk);
      if (hs) k++;
      t++;
    end
    s_valid = 1'b0; cfg_start = 1'b0;
    if (t >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout got=%0d beats want=%0d", k, n);
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cyc_q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      total++; bad++;
      $display("FAIL done_timeout got=%0d pulses want=%0d", done_cyc_q.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, mem_write_req, busy, done} !== 4'b0000 || mem_write_addr !== 14'h0 ||
        mem_write_data !== 256'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b addr=%h want=0000 addr=0",
               {s_ready, mem_write_req, busy, done}, mem_write_addr);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, mem_write_req, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_outputs got=%b want=0000", {s_ready, mem_write_req, busy, done});
    end
  endtask

  task automatic test_16bit();
    int s;
    for (int i = 0; i < 4; i++) beat_mem[i] = {8{32'hC0DE_0000 | 32'(i)}};
    clear_logs();
    do_start(1'b1, 13'h0100, 16'd4, 1'b0, 1'b0, s);
    send_beats(4, 16'hFFFF, 1'b0);
    wait_done(1);
    total++;
    if (wr_addr_q.size() != 4) begin
      bad++; $display("FAIL b16_count got=%0d want=4", wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== 14'h2100 + 14'(i)) begin
        bad++; $display("FAIL b16_addr[%0d] got=%h want=%h", i, wr_addr_q[i], 14'h2100 + 14'(i));
      end
      total++;
      if (wr_data_q[i] !== {8{32'hC0DE_0000 | 32'(i)}}) begin
        bad++; $display("FAIL b16_data[%0d] got=%h", i, wr_data_q[i]);
      end
      total++;
      if (wr_cyc_q[i] != s + 2 + i) begin
        bad++; $display("FAIL b16_cycle[%0d] got=%0d want=%0d", i, wr_cyc_q[i], s + 2 + i);
      end
    end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 6 || done_busy_q[0] !== 1'b0) begin
      bad++;
      $display("FAIL b16_done got=%0d pulses first=%0d want=1 pulse at %0d busy=0",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, s + 6);
    end
  endtask

  task automatic test_8bit(input logic sign);
    int s;
    logic [255:0] exp_w [0:3];
    beat_mem[0] = {8'h05, 112'h0, 8'h7F, 8'h90, 112'h0, 8'h80};
    beat_mem[1] = {120'h0, 8'hFE, 120'h0, 8'h01};
    if (sign) begin
      exp_w[0] = {16'hFF90, 224'h0, 16'hFF80};
      exp_w[1] = {16'h0005, 224'h0, 16'h007F};
      exp_w[2] = {240'h0, 16'h0001};
      exp_w[3] = {240'h0, 16'hFFFE};
    end else begin
      exp_w[0] = {16'h0090, 224'h0, 16'h0080};
      exp_w[1] = {16'h0005, 224'h0, 16'h007F};
      exp_w[2] = {240'h0, 16'h0001};
      exp_w[3] = {240'h0, 16'h00FE};
    end
    clear_logs();
    do_start(1'b0, 13'h0040, 16'd2, 1'b1, sign, s);
    send_beats(2, 16'hFFFF, 1'b0);
    wait_done(1);
    total++;
    if (wr_addr_q.size() != 4) begin
      bad++; $display("FAIL b8_count sign=%0d got=%0d want=4", sign, wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== 14'h0040 + 14'(i) || wr_cyc_q[i] != s + 2 + i) begin
        bad++;
        $display("FAIL b8_addr[%0d] got=%h@%0d want=%h@%0d", i, wr_addr_q[i], wr_cyc_q[i],
                 14'h0040 + 14'(i), s + 2 + i);
      end
      total++;
      if (wr_data_q[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL b8_data[%0d] sign=%0d got=%h want=%h", i, sign, wr_data_q[i], exp_w[i]);
      end
    end
    if (wr_ready_q.size() >= 2) begin
      total++;
      if (wr_ready_q[0] !== 1'b0 || wr_ready_q[1] !== 1'b1) begin
        bad++;
        $display("FAIL b8_ready got=%b%b want=01", wr_ready_q[0], wr_ready_q[1]);
      end
    end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 6) begin
      bad++; $display("FAIL b8_done got=%0d pulses want=1 at %0d", done_cyc_q.size(), s + 6);
    end
  endtask

  task automatic test_zero();
    int s;
    clear_logs();
    @(negedge clk);
    cfg_tag = 1'b1; cfg_base_addr = 13'h0300; cfg_num_beats = 16'd0;
    cfg_mode_8bit = 1'b0; cfg_sign_ext = 1'b0; cfg_start = 1'b1;
    s_valid = 1'b1; s_data = {8{32'hDEAD_BEEF}};
    s = cyc;
    @(negedge clk);
    cfg_num_beats = 16'd2;
    @(negedge clk);
    cfg_num_beats = 16'd0;
    @(negedge clk);
    cfg_start = 1'b0; s_valid = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (wr_addr_q.size() != 0 || ready_seen) begin
      bad++;
      $display("FAIL zero_writes got=%0d ready=%0d want=0 ready=0", wr_addr_q.size(), ready_seen);
    end
    total++;
    if (done_cyc_q.size() != 2 || done_cyc_q[0] != s + 1 || done_cyc_q[1] != s + 3) begin
      bad++;
      $display("FAIL zero_done got=%0d pulses want=2 at %0d,%0d", done_cyc_q.size(), s + 1, s + 3);
    end
  endtask

  task automatic test_wrap();
    int s;
    for (int i = 0; i < 3; i++) beat_mem[i] = {8{32'h0A0B_0000 | 32'(i)}};
    clear_logs();
    do_start(1'b0, 13'h1FFE, 16'd3, 1'b0, 1'b0, s);
    send_beats(3, 16'hFFFF, 1'b0);
    wait_done(1);
    total++;
    if (wr_addr_q.size() != 3 || wr_addr_q[0] !== 14'h1FFE || wr_addr_q[1] !== 14'h1FFF ||
        wr_addr_q[2] !== 14'h0000) begin
      bad++;
      $display("FAIL wrap_addr got=%0d writes want=1ffe,1fff,0000", wr_addr_q.size());
    end
  endtask

  task automatic test_gaps();
    int s;
    for (int i = 0; i < 6; i++) beat_mem[i] = {8{32'h5500_0000 | 32'(i * 17)}};
    clear_logs();
    do_start(1'b1, 13'h0010, 16'd6, 1'b0, 1'b0, s);
    send_beats(6, 16'b0110_1101_1001_1011, 1'b1);
    wait_done(1);
    total++;
    if (wr_addr_q.size() != 6) begin
      bad++; $display("FAIL gaps_count got=%0d want=6", wr_addr_q.size());
    end
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== 14'h2010 + 14'(i) || wr_data_q[i] !== {8{32'h5500_0000 | 32'(i * 17)}}) begin
        bad++;
        $display("FAIL gaps_write[%0d] got=%h want=%h", i, wr_addr_q[i], 14'h2010 + 14'(i));
      end
    end
    total++;
    if (done_cyc_q.size() != 1) begin
      bad++; $display("FAIL gaps_done got=%0d want=1", done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s;
    for (int i = 0; i < 5; i++) beat_mem[i] = {8{32'h7700_0000 | 32'(i)}};
    clear_logs();
    do_start(1'b1, 13'h0200, 16'd5, 1'b0, 1'b0, s);
    send_beats(2, 16'hFFFF, 1'b0);
    reset = 1'b0;
    #1;
    total++;
    if ({s_ready, mem_write_req, busy, done} !== 4'b0000 || mem_write_addr !== 14'h0 ||
        mem_write_data !== 256'h0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b addr=%h want=0000 addr=0",
               {s_ready, mem_write_req, busy, done}, mem_write_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    do_start(1'b0, 13'h0005, 16'd2, 1'b0, 1'b0, s);
    send_beats(2, 16'hFFFF, 1'b0);
    wait_done(1);
    total++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 14'h0005 || wr_addr_q[1] !== 14'h0006 ||
        wr_data_q[0] !== {8{32'h7700_0000}} || done_cyc_q.size() != 1) begin
      bad++;
      $display("FAIL midreset_restart got=%0d writes %0d done want=2 writes at 0005 1 done",
               wr_addr_q.size(), done_cyc_q.size());
    end
  endtask

  initial begin
    cfg_start = 1'b0; cfg_tag = 1'b0; cfg_base_addr = 13'h0; cfg_num_beats = 16'd0;
    cfg_mode_8bit = 1'b0; cfg_sign_ext = 1'b0; s_data = 256'h0; s_valid = 1'b0;
    reset = 1'b0;
    test_reset();
    test_16bit();
    test_8bit(1'b1);
    test_8bit(1'b0);
    test_zero();
    test_wrap();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
